child_slot_scheduler: RTL and testbench

Round-robin scheduler that shares one exclusive resource slot among the five child instances of a generated root module. Each child raises a request, receives a one-hot grant, and returns it with a done pulse. A hold-time watchdog forcibly revokes the grant from a child that never finishes. The block sits beside the child instances inside the root module, one per root.

---
 rtl/child_slot_scheduler.sv | 135 +++++++++++++
 tb/tb_child_slot_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/child_slot_scheduler.sv
// Round-robin owner of one exclusive slot shared by the root's child instances.
// A hold-time watchdog revokes the grant from a child that never releases it.
module child_slot_scheduler #(
   parameter int N_REQ    = 5,
   parameter int HOLD_MAX = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic [2:0]       owner,
   output logic             timeout,
   output logic [2:0]       timeout_id
);

   // state | meaning
   // IDLE  | no owner, waiting for any request
   // GRANT | one child owns the slot, hold counter running
   // GAP   | single dead cycle between owners

   localparam int             CW      = $clog2(HOLD_MAX + 1);
   localparam logic [2:0]     PTR_RST = 3'(N_REQ - 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(HOLD_MAX);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t           state, state_nxt;
   logic [2:0]       ptr, ptr_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [N_REQ-1:0] grant_nxt;
   logic             busy_nxt;
   logic [2:0]       owner_nxt;
   logic             timeout_nxt;
   logic [2:0]       timeout_id_nxt;

   logic [2:0]       sel;
   logic             sel_vld;
   logic             own_req;
   logic             own_done;
   logic             rel;
   logic             at_max;

   // Walk the search order backwards so the nearest requester after ptr wins.
   always_comb begin
      int         idx;
      logic [2:0] idx3;
      sel     = '0;
      sel_vld = 1'b0;
      idx     = 0;
      idx3    = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         idx3 = 3'(idx);
         if (req[idx3]) begin
            sel     = idx3;
            sel_vld = 1'b1;
         end
      end
   end

   assign own_req  = req[owner];
   assign own_done = done[owner];
   assign rel      = own_done | ~own_req;
   assign at_max   = (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= PTR_RST;
         cnt        <= '0;
         grant      <= '0;
         busy       <= 1'b0;
         owner      <= '0;
         timeout    <= 1'b0;
         timeout_id <= '0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         cnt        <= cnt_nxt;
         grant      <= grant_nxt;
         busy       <= busy_nxt;
         owner      <= owner_nxt;
         timeout    <= timeout_nxt;
         timeout_id <= timeout_id_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, GAP: state_nxt = sel_vld ? GRANT : IDLE;
         GRANT:     state_nxt = (rel || at_max) ? GAP : GRANT;
         default:   state_nxt = IDLE;
      endcase
   end

   // Release has priority over the watchdog when both land on the same cycle.
   always_comb begin
      grant_nxt      = '0;
      owner_nxt      = owner;
      ptr_nxt        = ptr;
      cnt_nxt        = '0;
      timeout_nxt    = 1'b0;
      timeout_id_nxt = timeout_id;
      case (state)
         IDLE, GAP: begin
            if (sel_vld) begin
               grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
               owner_nxt = sel;
               cnt_nxt   = CW'(1);
            end
         end
         GRANT: begin
            if (rel) begin
               ptr_nxt = owner;
            end else if (at_max) begin
               ptr_nxt        = owner;
               timeout_nxt    = 1'b1;
               timeout_id_nxt = owner;
            end else begin
               grant_nxt = grant;
               cnt_nxt   = cnt + CW'(1);
            end
         end
         default: begin
            grant_nxt = '0;
         end
      endcase
      busy_nxt = |grant_nxt;
   end

endmodule

// File: tb/tb_child_slot_scheduler.sv
// Scenario bench for child_slot_scheduler: expected owners are queued when
// requests are driven and popped as grants appear.
module tb_child_slot_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] req = '0;
   logic [4:0] done = '0;
   logic [4:0] grant;
   logic       busy;
   logic [2:0] owner;
   logic       timeout;
   logic [2:0] timeout_id;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   child_slot_scheduler #(.N_REQ(5), .HOLD_MAX(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .done       (done),
      .grant      (grant),
      .busy       (busy),
      .owner      (owner),
      .timeout    (timeout),
      .timeout_id (timeout_id)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   task automatic wait_grant(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 40) begin
         @(negedge clk);
         n++;
         if (grant !== 5'b00000) ok = 1'b1;
      end
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      req   = '0;
      done  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      req   = 5'b11111;
      repeat (2) @(negedge clk);
      checks++;
      if (grant !== 5'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_grant grant=%b busy=%b required 00000/0", grant, busy);
      end
      checks++;
      if (owner !== 3'd0 || timeout !== 1'b0 || timeout_id !== 3'd0) begin
         errors++;
         $display("FAIL reset_misc owner=%0d timeout=%b timeout_id=%0d required 0/0/0",
                  owner, timeout, timeout_id);
      end
      req = '0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_priority;
      int n;
      bit ok;
      int e;
      do_reset;
      exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(0);
      req = 5'b10101;
      for (int g = 0; g < 4; g++) begin
         wait_grant(n, ok);
         checks++;
         if (!ok || n != 1) begin
            errors++;
            $display("FAIL prio_latency grant#%0d waited %0d cycles, required 1", g, n);
         end
         e = exp_q.pop_front();
         checks++;
         if (grant !== 5'(1 << e) || owner !== 3'(e) || busy !== 1'b1) begin
            errors++;
            $display("FAIL prio_owner grant=%b owner=%0d busy=%b required owner %0d busy 1",
                     grant, owner, busy, e);
         end
         done = 5'(1 << e);
         @(negedge clk);
         done = '0;
         checks++;
         if (grant !== 5'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL prio_gap grant=%b busy=%b required 00000/0", grant, busy);
         end
      end
      req = '0;
   endtask

   task automatic test_fairness;
      int n;
      bit ok;
      int e;
      int cnt_per[5];
      do_reset;
      for (int i = 0; i < 5; i++) cnt_per[i] = 0;
      for (int i = 0; i < 10; i++) exp_q.push_back(i % 5);
      req = 5'b11111;
      for (int g = 0; g < 10; g++) begin
         wait_grant(n, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || n != 1 || grant !== 5'(1 << e) || owner !== 3'(e)) begin
            errors++;
            $display("FAIL rr_owner grant#%0d grant=%b owner=%0d wait=%0d required owner %0d wait 1",
                     g, grant, owner, n, e);
         end
         if (owner < 5) cnt_per[owner]++;
         done = 5'(1 << e);
         @(negedge clk);
         done = '0;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cnt_per[i] != 2) begin
            errors++;
            $display("FAIL rr_count child %0d got %0d grants, required 2", i, cnt_per[i]);
         end
      end
      req = '0;
   endtask

   task automatic test_timeout;
      int n;
      bit ok;
      int e;
      int hold;
      do_reset;
      exp_q.push_back(3);
      req = 5'b01000;
      wait_grant(n, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || grant !== 5'(1 << e) || timeout !== 1'b0) begin
         errors++;
         $display("FAIL to_grant grant=%b timeout=%b required %b/0", grant, timeout, 5'(1 << e));
      end
      hold = 1;
      while (hold < 40) begin
         @(negedge clk);
         if (grant !== 5'b01000) break;
         hold++;
      end
      checks++;
      if (hold != 16) begin
         errors++;
         $display("FAIL to_hold grant held %0d cycles, required 16", hold);
      end
      checks++;
      if (grant !== 5'b0 || timeout !== 1'b1 || timeout_id !== 3'd3) begin
         errors++;
         $display("FAIL to_pulse grant=%b timeout=%b timeout_id=%0d required 00000/1/3",
                  grant, timeout, timeout_id);
      end
      exp_q.push_back(3);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (grant !== 5'(1 << e) || timeout !== 1'b0 || timeout_id !== 3'd3) begin
         errors++;
         $display("FAIL to_regrant grant=%b timeout=%b timeout_id=%0d required 01000/0/3",
                  grant, timeout, timeout_id);
      end
      req = '0;
   endtask

   task automatic test_simultaneous;
      int n;
      bit ok;
      int e;
      do_reset;
      exp_q.push_back(2);
      req = 5'b00100;
      wait_grant(n, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || grant !== 5'(1 << e)) begin
         errors++;
         $display("FAIL sim_grant grant=%b required %b", grant, 5'(1 << e));
      end
      done = 5'b00010;
      for (int i = 2; i <= 16; i++) begin
         @(negedge clk);
         checks++;
         if (grant !== 5'b00100 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL sim_hold cycle %0d grant=%b timeout=%b required 00100/0",
                     i, grant, timeout);
         end
         if (i < 6) done = 5'b00010;
         else if (i == 16) done = 5'b00100;
         else done = '0;
      end
      @(negedge clk);
      done = '0;
      checks++;
      if (grant !== 5'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL sim_release grant=%b timeout=%b required 00000/0", grant, timeout);
      end
      exp_q.push_back(2);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (grant !== 5'(1 << e) || timeout !== 1'b0) begin
         errors++;
         $display("FAIL sim_regrant grant=%b timeout=%b required 00100/0", grant, timeout);
      end
      req = '0;
   endtask

   task automatic test_req_drop;
      int n;
      bit ok;
      int e;
      do_reset;
      exp_q.push_back(4);
      req = 5'b10000;
      wait_grant(n, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || n != 1 || grant !== 5'(1 << e) || owner !== 3'd4) begin
         errors++;
         $display("FAIL drop_grant grant=%b owner=%0d wait=%0d required 10000/4/1",
                  grant, owner, n);
      end
      repeat (3) @(negedge clk);
      req = 5'b00001;
      exp_q.push_back(0);
      @(negedge clk);
      checks++;
      if (grant !== 5'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL drop_gap grant=%b busy=%b timeout=%b required 00000/0/0",
                  grant, busy, timeout);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (grant !== 5'(1 << e) || owner !== 3'(e)) begin
         errors++;
         $display("FAIL drop_next grant=%b owner=%0d required owner %0d", grant, owner, e);
      end
      req = '0;
   endtask

   task automatic test_reset_mid;
      int n;
      bit ok;
      int e;
      do_reset;
      exp_q.push_back(0);
      req = 5'b00001;
      wait_grant(n, ok);
      e = exp_q.pop_front();
      done = 5'(1 << e);
      req  = 5'b00010;
      exp_q.push_back(1);
      @(negedge clk);
      done = '0;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (grant !== 5'(1 << e) || owner !== 3'd1) begin
         errors++;
         $display("FAIL mid_setup grant=%b owner=%0d required 00010/1", grant, owner);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (grant !== 5'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_async grant=%b busy=%b required 00000/0", grant, busy);
      end
      @(negedge clk);
      checks++;
      if (timeout !== 1'b0 || owner !== 3'd0) begin
         errors++;
         $display("FAIL mid_state timeout=%b owner=%0d required 0/0", timeout, owner);
      end
      req   = 5'b00011;
      rst_n = 1'b1;
      exp_q.push_back(0);
      exp_q.push_back(1);
      wait_grant(n, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || n != 1 || grant !== 5'(1 << e)) begin
         errors++;
         $display("FAIL mid_ptr grant=%b wait=%0d required %b wait 1", grant, n, 5'(1 << e));
      end
      done = 5'(1 << e);
      @(negedge clk);
      done = '0;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (grant !== 5'(1 << e) || owner !== 3'(e)) begin
         errors++;
         $display("FAIL mid_next grant=%b owner=%0d required owner %0d", grant, owner, e);
      end
      req = '0;
   endtask

   initial begin
      test_reset;
      test_reset_priority;
      test_fairness;
      test_timeout;
      test_simultaneous;
      test_req_drop;
      test_reset_mid;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain %0d entries left, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
